// File: rtl/wash_input_conditioner.sv
// Washer controller front end: synchronises and debounces panel/sensor switches, tracks coin credit,
// and produces the controller's sig_* inputs. Define WATCHDOG_EN to replace raw_Time_Out with a stall watchdog.
module wash_input_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          COINS_REQUIRED  = 2,
    parameter int          CREDIT_W        = 3,
    parameter logic [2:0]  IDLE_STATE      = 3'd0,
    parameter int          TIMEOUT_CYCLES  = 1000,
    parameter int          TIMER_W         = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                raw_Lid,
    input  logic                raw_Coin,
    input  logic                raw_Cancel,
    input  logic                raw_Time_Out,
    input  logic                raw_Out_Of_Balance,
    input  logic                raw_Motor_Failure,
    input  logic [2:0]          state,
    output logic                sig_Lid_Closed,
    output logic                sig_Coin,
    output logic                sig_Cancel,
    output logic                sig_Time_Out,
    output logic                sig_Out_Of_Balance,
    output logic                sig_Motor_Failure,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_Refund
);

    localparam int N_IN   = 6;
    localparam int I_LID  = 0;
    localparam int I_COIN = 1;
    localparam int I_CAN  = 2;
    localparam int I_TO   = 3;
    localparam int I_OOB  = 4;
    localparam int I_MF   = 5;

    localparam logic [TIMER_W-1:0]  DB_LIMIT = TIMER_W'(DEBOUNCE_CYCLES);
    localparam logic [CREDIT_W-1:0] CR_LIMIT = CREDIT_W'(COINS_REQUIRED);

    logic [N_IN-1:0]    raw_vec;
    logic [N_IN-1:0]    sync1_q, sync2_q, level_q;
    logic [TIMER_W-1:0] db_cnt_q [N_IN];

    assign raw_vec = {raw_Motor_Failure, raw_Out_Of_Balance, raw_Time_Out,
                      raw_Cancel, raw_Coin, raw_Lid};

    // Counter runs only while synced level disagrees with the debounced level; any bounce back clears it.
    // NOTE: the counter array is a handful of flops, not a RAM, so every element is reset explicitly.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            for (int i = 0; i < N_IN; i++) db_cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let sync2_q take the old sync1_q, forming a real 2-flop chain.
            sync1_q <= raw_vec;
            sync2_q <= sync1_q;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LIMIT) begin
                    level_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + TIMER_W'(1);
                end
            end
        end
    end

    logic                coin_prev_q, cancel_prev_q;
    logic                coin_rise, cancel_rise;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                sig_coin_q, sig_coin_d;
    logic                cancel_q, cancel_d;
    logic                refund_q, refund_d;

    assign coin_rise   = level_q[I_COIN] & ~coin_prev_q;
    assign cancel_rise = level_q[I_CAN]  & ~cancel_prev_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        credit_d = credit_q;
        refund_d = 1'b0;
        cancel_d = cancel_rise;
        if (state != IDLE_STATE) begin
            credit_d = '0;
            refund_d = coin_rise;
        end else if (cancel_rise) begin
            credit_d = '0;
            refund_d = (credit_q != '0) | coin_rise;
        end else if (coin_rise) begin
            if (credit_q < CR_LIMIT) credit_d = credit_q + CREDIT_W'(1);
            else                     refund_d = 1'b1;
        end
        sig_coin_d = (credit_d == CR_LIMIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coin_prev_q   <= 1'b0;
            cancel_prev_q <= 1'b0;
            credit_q      <= '0;
            sig_coin_q    <= 1'b0;
            cancel_q      <= 1'b0;
            refund_q      <= 1'b0;
        end else begin
            coin_prev_q   <= level_q[I_COIN];
            cancel_prev_q <= level_q[I_CAN];
            credit_q      <= credit_d;
            sig_coin_q    <= sig_coin_d;
            cancel_q      <= cancel_d;
            refund_q      <= refund_d;
        end
    end

`ifdef WATCHDOG_EN
    logic [2:0]         state_q;
    logic [TIMER_W-1:0] wd_cnt_q;
    logic               timeout_q;
    logic               unused_timeout_path;

    assign unused_timeout_path = level_q[I_TO];

    // Any state change (or idle) restarts the stall window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state;
            if (state == IDLE_STATE || state != state_q) begin
                wd_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end else if (wd_cnt_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt_q  <= '0;
                timeout_q <= 1'b1;
            end else begin
                wd_cnt_q  <= wd_cnt_q + TIMER_W'(1);
                timeout_q <= 1'b0;
            end
        end
    end

    assign sig_Time_Out = timeout_q;
`else
    assign sig_Time_Out = level_q[I_TO];
`endif

    assign sig_Lid_Closed     = level_q[I_LID];
    assign sig_Out_Of_Balance = level_q[I_OOB];
    assign sig_Motor_Failure  = level_q[I_MF];
    assign sig_Coin           = sig_coin_q;
    assign sig_Cancel         = cancel_q;
    assign credit             = credit_q;
    assign coin_Refund        = refund_q;

endmodule
